// File: rtl/axis_seq_pkg.sv
// rtl/axis_seq_pkg.sv - shared state, header and error-bit definitions for the frame sequencer
package axis_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_WEIGHT,
      S_DATA,
      S_WAIT_OUT,
      S_DISCARD
   } seq_state_t;

   localparam int HDR_LEN_LSB      = 0;
   localparam int ERR_EARLY_LAST   = 0;
   localparam int ERR_MISSING_LAST = 1;
   localparam int ERR_RESULT       = 2;

   // The weight flag sits directly above the length field, whose width is a module parameter.
   function automatic int hdr_wflag_bit(input int len_w);
      return HDR_LEN_LSB + len_w;
   endfunction

endpackage

// File: rtl/seq_result_counter.sv
// rtl/seq_result_counter.sv - result path: counts results, marks frame end, watchdog and stray-result check
module seq_result_counter
   import axis_seq_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 4096
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              i_active,
   input  logic              i_in_wait,
   input  logic              i_clear,
   input  logic              i_set_exp,
   input  logic [LEN_W-1:0]  i_exp,
   input  logic [DATA_W-1:0] i_y_data,
   input  logic              i_y_valid,
   output logic [DATA_W-1:0] o_m_tdata,
   output logic              o_m_tvalid,
   output logic              o_m_tlast,
   output logic              o_frame_done,
   output logic              o_done,
   output logic              o_timeout,
   output logic              o_unexpected
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   logic [LEN_W-1:0]  r_count;
   logic [LEN_W-1:0]  r_exp;
   logic [WD_W-1:0]   r_wd;
   logic [DATA_W-1:0] r_m_tdata;
   logic              r_m_tvalid;
   logic              r_m_tlast;
   logic              r_frame_done;

   logic              w_room;
   logic              w_emit;
   logic              w_reach;
   logic [LEN_W-1:0]  w_count_inc;

   assign w_count_inc  = r_count + 1'b1;
   assign w_room       = (r_count != r_exp);
   assign w_emit       = i_active & i_y_valid & w_room;
   assign w_reach      = (w_count_inc == r_exp);
   assign o_done       = ~w_room;
   assign o_unexpected = i_y_valid & ~w_emit;
   // Watchdog fires on the TIMEOUT-th consecutive result-free cycle while results are still owed.
   assign o_timeout    = i_in_wait & w_room & ~i_y_valid & (r_wd == WD_LAST);

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_count      <= '0;
         r_exp        <= '0;
         r_wd         <= '0;
         r_m_tdata    <= '0;
         r_m_tvalid   <= 1'b0;
         r_m_tlast    <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_m_tdata    <= i_y_data;
         r_m_tvalid   <= w_emit;
         r_m_tlast    <= w_emit & w_reach;
         r_frame_done <= w_emit & w_reach;
         if (i_clear) begin
            r_count <= '0;
         end else if (w_emit) begin
            r_count <= w_count_inc;
         end
         if (i_set_exp) begin
            r_exp <= i_exp;
         end
         if (!i_in_wait || i_y_valid) begin
            r_wd <= '0;
         end else if (w_room) begin
            r_wd <= r_wd + 1'b1;
         end
      end
   end

   assign o_m_tdata    = r_m_tdata;
   assign o_m_tvalid   = r_m_tvalid;
   assign o_m_tlast    = r_m_tlast;
   assign o_frame_done = r_frame_done;

endmodule

// File: rtl/axis_frame_sequencer.sv
// rtl/axis_frame_sequencer.sv - frame sequencer between DMA streams and the process core
// Parses the header, forwards weight and data beats, and checks frame integrity.
module axis_frame_sequencer
   import axis_seq_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int N       = 8,
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 4096
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   input  logic              s_tlast,
   output logic              s_tready,
   output logic [DATA_W-1:0] core_tdata,
   output logic              core_w_valid,
   output logic              core_x_valid,
   output logic              core_x_last,
   input  logic [DATA_W-1:0] core_y_data,
   input  logic              core_y_valid,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   output logic              m_tlast,
   output logic              busy,
   output logic              frame_done,
   output logic [2:0]        err_flags
);

   localparam int HDR_WFLAG_BIT = hdr_wflag_bit(LEN_W);
   localparam int WC_W = $clog2(N + 1);

   seq_state_t        r_state;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_dcnt;
   logic [WC_W-1:0]   r_wcnt;
   logic [2:0]        r_err;
   logic [DATA_W-1:0] r_core_tdata;
   logic              r_core_w_valid;
   logic              r_core_x_valid;
   logic              r_core_x_last;

   logic              w_acc;
   logic              w_hdr_acc;
   logic              w_early_last;
   logic              w_data_last;
   logic              w_res_active;
   logic              w_done;
   logic              w_timeout;
   logic              w_unexp;
   logic [LEN_W-1:0]  w_hdr_len;
   logic [LEN_W-1:0]  w_next_dcnt;

   assign s_tready     = (r_state == S_HDR) || (r_state == S_WEIGHT) ||
                         (r_state == S_DATA) || (r_state == S_DISCARD);
   assign w_acc        = s_tvalid & s_tready;
   assign w_hdr_len    = s_tdata[HDR_LEN_LSB +: LEN_W];
   assign w_next_dcnt  = r_dcnt + 1'b1;
   assign w_data_last  = (w_next_dcnt == r_len);
   assign w_hdr_acc    = w_acc & (r_state == S_HDR);
   assign w_early_last = w_acc & (r_state == S_DATA) & s_tlast & ~w_data_last;
   // Results may overlap the input phases, so the result path runs outside IDLE/HDR.
   assign w_res_active = (r_state == S_WEIGHT) || (r_state == S_DATA) ||
                         (r_state == S_DISCARD) || (r_state == S_WAIT_OUT);

   seq_result_counter #(
      .DATA_W  (DATA_W),
      .LEN_W   (LEN_W),
      .TIMEOUT (TIMEOUT)
   ) u_res (
      .aclk         (aclk),
      .areset       (areset),
      .i_active     (w_res_active),
      .i_in_wait    (r_state == S_WAIT_OUT),
      .i_clear      (w_hdr_acc),
      .i_set_exp    (w_hdr_acc | w_early_last),
      .i_exp        (w_hdr_acc ? w_hdr_len : w_next_dcnt),
      .i_y_data     (core_y_data),
      .i_y_valid    (core_y_valid),
      .o_m_tdata    (m_tdata),
      .o_m_tvalid   (m_tvalid),
      .o_m_tlast    (m_tlast),
      .o_frame_done (frame_done),
      .o_done       (w_done),
      .o_timeout    (w_timeout),
      .o_unexpected (w_unexp)
   );

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state        <= S_IDLE;
         r_len          <= '0;
         r_dcnt         <= '0;
         r_wcnt         <= '0;
         r_err          <= '0;
         r_core_tdata   <= '0;
         r_core_w_valid <= 1'b0;
         r_core_x_valid <= 1'b0;
         r_core_x_last  <= 1'b0;
      end else begin
         r_core_tdata   <= s_tdata;
         r_core_w_valid <= 1'b0;
         r_core_x_valid <= 1'b0;
         r_core_x_last  <= 1'b0;
         if (w_unexp || w_timeout) begin
            r_err[ERR_RESULT] <= 1'b1;
         end
         case (r_state)
            S_IDLE: r_state <= S_HDR;
            S_HDR: begin
               if (w_acc) begin
                  r_len  <= w_hdr_len;
                  r_dcnt <= '0;
                  r_wcnt <= '0;
                  if (w_hdr_len == '0) begin
                     r_err[ERR_EARLY_LAST] <= 1'b1;
                     r_state <= s_tlast ? S_IDLE : S_DISCARD;
                  end else if (s_tlast) begin
                     r_err[ERR_EARLY_LAST] <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= s_tdata[HDR_WFLAG_BIT] ? S_WEIGHT : S_DATA;
                  end
               end
            end
            S_WEIGHT: begin
               if (w_acc) begin
                  if (s_tlast) begin
                     r_err[ERR_EARLY_LAST] <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_core_w_valid <= 1'b1;
                     r_wcnt <= r_wcnt + 1'b1;
                     if (r_wcnt == WC_W'(N - 1)) begin
                        r_state <= S_DATA;
                     end
                  end
               end
            end
            S_DATA: begin
               if (w_acc) begin
                  r_core_x_valid <= 1'b1;
                  r_core_x_last  <= w_data_last | s_tlast;
                  r_dcnt         <= w_next_dcnt;
                  if (s_tlast) begin
                     if (!w_data_last) begin
                        r_err[ERR_EARLY_LAST] <= 1'b1;
                     end
                     r_state <= S_WAIT_OUT;
                  end else if (w_data_last) begin
                     r_err[ERR_MISSING_LAST] <= 1'b1;
                     r_state <= S_DISCARD;
                  end
               end
            end
            S_DISCARD: begin
               if (w_acc && s_tlast) begin
                  r_state <= S_WAIT_OUT;
               end
            end
            S_WAIT_OUT: begin
               if (w_done || w_timeout) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign core_tdata   = r_core_tdata;
   assign core_w_valid = r_core_w_valid;
   assign core_x_valid = r_core_x_valid;
   assign core_x_last  = r_core_x_last;
   assign busy         = (r_state != S_IDLE);
   assign err_flags    = r_err;

endmodule
